// File: rtl/loop_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : loop_addr_gen
// Description : Nested-loop address generator. Holds a base address and one
//               stride per loop level, and turns each incoming iteration tuple
//               into base + sum(iter[l] * stride[l]) through a two-stage,
//               stall-able pipeline (products, then sum).
// Revision    : 1.0 - initial release
// ============================================================================
module loop_addr_gen #(
   parameter int LOOP_ID_W     = 3,
   parameter int NUM_MAX_LOOPS = 1 << LOOP_ID_W,
   parameter int LOOP_ITER_W   = 16,
   parameter int STRIDE_W      = 16,
   parameter int ADDR_W        = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               block_done,
   input  logic                               cfg_base_addr_v,
   input  logic [ADDR_W-1:0]                  cfg_base_addr,
   input  logic                               cfg_stride_v,
   input  logic [STRIDE_W-1:0]                cfg_stride,
   input  logic                               iter_v,
   input  logic                               iter_last,
   input  logic [LOOP_ITER_W*NUM_MAX_LOOPS-1:0] current_iters,
   input  logic                               stall,
   output logic                               addr_v,
   output logic [ADDR_W-1:0]                  addr,
   output logic                               addr_last,
   output logic [LOOP_ID_W:0]                 cfg_loop_count
);

   // Saturation point of the stride counter and its increment, at counter width
   localparam logic [LOOP_ID_W:0] c_MAX_CNT = (LOOP_ID_W + 1)'(NUM_MAX_LOOPS);
   localparam logic [LOOP_ID_W:0] c_CNT_ONE = (LOOP_ID_W + 1)'(1);

   // Configuration state
   logic [ADDR_W-1:0]   base_q;
   logic [STRIDE_W-1:0] stride_q [NUM_MAX_LOOPS];
   logic [LOOP_ID_W:0]  cnt_q;

   // Stage 1: per-loop products
   logic [ADDR_W-1:0]   prod_d [NUM_MAX_LOOPS];
   logic [ADDR_W-1:0]   prod_q [NUM_MAX_LOOPS];
   logic                v1_q;
   logic                last1_q;

   // Stage 2: final address
   logic [ADDR_W-1:0]   addr_d;
   logic [ADDR_W-1:0]   addr_q;
   logic                addr_v_q;
   logic                addr_last_q;

   // Configuration registers: base persists across blocks, strides fill in
   // loop order and are wiped by block_done (which wins over a stride write)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q <= '0;
         cnt_q  <= '0;
         for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
            stride_q[l] <= '0;
         end
      end else begin
         if (cfg_base_addr_v) begin
            base_q <= cfg_base_addr;
         end
         if (block_done) begin
            cnt_q <= '0;
            for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
               stride_q[l] <= '0;
            end
         end else if (cfg_stride_v && (cnt_q < c_MAX_CNT)) begin
            for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
               if (cnt_q == (LOOP_ID_W + 1)'(l)) begin
                  stride_q[l] <= cfg_stride;
               end
            end
            cnt_q <= cnt_q + c_CNT_ONE;
         end
      end
   end

   // Operands are widened to ADDR_W before multiplying, so the product is the
   // true product reduced modulo 2^ADDR_W regardless of operand widths
   generate
      for (genvar l = 0; l < NUM_MAX_LOOPS; l++) begin : g_prod
         assign prod_d[l] = ADDR_W'(current_iters[LOOP_ITER_W*l +: LOOP_ITER_W])
                          * ADDR_W'(stride_q[l]);
      end
   endgenerate

   // Sum of the captured products on top of the current base, wrapping
   always_comb begin
      addr_d = base_q;
      for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
         addr_d = addr_d + prod_q[l];
      end
   end

   // Stage 1 register: capture products and tuple flags unless stalled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1_q    <= 1'b0;
         last1_q <= 1'b0;
         for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
            prod_q[l] <= '0;
         end
      end else if (!stall) begin
         v1_q    <= iter_v;
         last1_q <= iter_v & iter_last;
         for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
            prod_q[l] <= prod_d[l];
         end
      end
   end

   // Stage 2 register: present the address; held while stalled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q      <= '0;
         addr_v_q    <= 1'b0;
         addr_last_q <= 1'b0;
      end else if (!stall) begin
         addr_q      <= addr_d;
         addr_v_q    <= v1_q;
         addr_last_q <= last1_q;
      end
   end

   assign addr           = addr_q;
   assign addr_v         = addr_v_q;
   assign addr_last      = addr_last_q;
   assign cfg_loop_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_loop_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_loop_addr_gen
// Description : Scoreboard bench for loop_addr_gen. The stimulus side pushes
//               the hand-computed address of every tuple it issues; a monitor
//               pops and compares whenever an address is accepted downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loop_addr_gen;

   localparam int LID = 3;
   localparam int NL  = 8;
   localparam int IW  = 16;
   localparam int SW  = 16;
   localparam int AW  = 32;

   typedef struct {
      logic [AW-1:0] a;
      logic          l;
      int            cyc;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               block_done;
   logic               cfg_base_addr_v;
   logic [AW-1:0]      cfg_base_addr;
   logic               cfg_stride_v;
   logic [SW-1:0]      cfg_stride;
   logic               iter_v;
   logic               iter_last;
   logic [IW*NL-1:0]   current_iters;
   logic               stall;
   logic               addr_v;
   logic [AW-1:0]      addr;
   logic               addr_last;
   logic [LID:0]       cfg_loop_count;

   exp_t sb [$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   loop_addr_gen #(
      .LOOP_ID_W     (LID),
      .NUM_MAX_LOOPS (NL),
      .LOOP_ITER_W   (IW),
      .STRIDE_W      (SW),
      .ADDR_W        (AW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .block_done      (block_done),
      .cfg_base_addr_v (cfg_base_addr_v),
      .cfg_base_addr   (cfg_base_addr),
      .cfg_stride_v    (cfg_stride_v),
      .cfg_stride      (cfg_stride),
      .iter_v          (iter_v),
      .iter_last       (iter_last),
      .current_iters   (current_iters),
      .stall           (stall),
      .addr_v          (addr_v),
      .addr            (addr),
      .addr_last       (addr_last),
      .cfg_loop_count  (cfg_loop_count)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency expectations
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Monitor: an address is consumed on any cycle it is valid with stall low
   always @(negedge clk) begin
      if (reset) begin
         if (addr_v && !stall) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_addr: got addr 0x%0h, expected no output", addr);
            end else begin
               mon_e = sb.pop_front();
               chk("addr", {32'h0, addr}, {32'h0, mon_e.a});
               chk("addr_last", {63'h0, addr_last}, {63'h0, mon_e.l});
               if (mon_e.cyc >= 0) chk("latency", 64'(cyc), 64'(mon_e.cyc));
            end
         end else if (!addr_v) begin
            chk("bubble_last", {63'h0, addr_last}, 64'h0);
         end
      end
   end

   function automatic logic [IW*NL-1:0] it2(input logic [IW-1:0] a, input logic [IW-1:0] b);
      logic [IW*NL-1:0] r;
      r = '0;
      r[IW-1:0]    = a;
      r[2*IW-1:IW] = b;
      return r;
   endfunction

   function automatic logic [IW*NL-1:0] it_all(input logic [IW-1:0] v);
      logic [IW*NL-1:0] r;
      for (int l = 0; l < NL; l++) r[IW*l +: IW] = v;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      block_done      = 1'b0;
      cfg_base_addr_v = 1'b0;
      cfg_stride_v    = 1'b0;
      iter_v          = 1'b0;
      iter_last       = 1'b0;
      stall           = 1'b0;
   endtask

   task automatic send(input logic [IW*NL-1:0] it, input logic lst,
                       input logic [AW-1:0] ea, input bit lat);
      exp_t e;
      step();
      iter_v        = 1'b1;
      iter_last     = lst;
      current_iters = it;
      e.a   = ea;
      e.l   = lst;
      e.cyc = lat ? cyc + 2 : -1;
      sb.push_back(e);
   endtask

   task automatic set_base(input logic [AW-1:0] b);
      step();
      cfg_base_addr_v = 1'b1;
      cfg_base_addr   = b;
   endtask

   task automatic wr_stride(input logic [SW-1:0] s);
      step();
      cfg_stride_v = 1'b1;
      cfg_stride   = s;
   endtask

   task automatic blk_done(input logic with_stride);
      step();
      block_done   = 1'b1;
      cfg_stride_v = with_stride;
      cfg_stride   = 16'h0077;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) step();
      chk("drain_queue_empty", 64'(sb.size()), 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [IW*NL-1:0] it;
      int idx;
      reset           = 1'b0;
      block_done      = 1'b0;
      cfg_base_addr_v = 1'b0;
      cfg_base_addr   = '0;
      cfg_stride_v    = 1'b0;
      cfg_stride      = '0;
      iter_v          = 1'b0;
      iter_last       = 1'b0;
      current_iters   = '0;
      stall           = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_addr_v", {63'h0, addr_v}, 64'h0);
      chk("rst_addr", {32'h0, addr}, 64'h0);
      chk("rst_addr_last", {63'h0, addr_last}, 64'h0);
      chk("rst_count", {60'h0, cfg_loop_count}, 64'h0);
      reset = 1'b1;

      // Two-loop sweep
      set_base(32'h0000_1000);
      wr_stride(16'd64);
      wr_stride(16'd4);
      step();
      chk("sweep_count", {60'h0, cfg_loop_count}, 64'd2);
      for (int i0 = 0; i0 < 3; i0++) begin
         for (int i1 = 0; i1 < 4; i1++) begin
            send(it2(IW'(i0), IW'(i1)), (i0 == 2 && i1 == 3),
                 32'h0000_1000 + 32'(64 * i0) + 32'(4 * i1), 1'b1);
         end
      end
      drain();

      // Stall for three cycles while an address is presented
      idx = 0;
      for (int t = 0; t < 8; t++) begin
         if (t >= 3 && t <= 5) begin
            step();
            stall = 1'b1;
            #2;
            chk("stall_addr_v", {63'h0, addr_v}, 64'h1);
            chk("stall_addr_frozen", {32'h0, addr}, 64'h0000_1004);
         end else begin
            send(it2(16'd0, IW'(idx)), 1'b0, 32'h0000_1000 + 32'(4 * idx), 1'b0);
            idx++;
         end
      end
      drain();

      // Reset with two tuples in flight
      send(it2(16'd1, 16'd1), 1'b0, 32'h0000_1044, 1'b0);
      send(it2(16'd2, 16'd2), 1'b0, 32'h0000_1088, 1'b0);
      chk("count_pre_reset", {60'h0, cfg_loop_count}, 64'd2);
      @(posedge clk);
      #2;
      sb.delete();
      iter_v = 1'b0;
      reset  = 1'b0;
      #1;
      chk("midrst_addr_v", {63'h0, addr_v}, 64'h0);
      chk("midrst_addr", {32'h0, addr}, 64'h0);
      chk("midrst_count", {60'h0, cfg_loop_count}, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (4) step();
      send(it2(16'd3, 16'd5), 1'b1, 32'h0, 1'b1);
      drain();

      // Only loop 0 configured: loop 1 and above contribute nothing
      set_base(32'h0000_2000);
      wr_stride(16'd8);
      step();
      chk("unconf_count", {60'h0, cfg_loop_count}, 64'd1);
      it = it_all(16'd7);
      it[IW-1:0]    = 16'd3;
      it[2*IW-1:IW] = 16'd5;
      send(it, 1'b0, 32'h0000_2018, 1'b1);
      drain();

      // Wrap of the sum modulo 2^32
      blk_done(1'b0);
      set_base(32'hFFFF_FFF0);
      wr_stride(16'h0020);
      send(it2(16'd1, 16'd9), 1'b0, 32'h0000_0010, 1'b1);
      send(it2(16'hFFFF, 16'd0), 1'b0, 32'h001F_FFD0, 1'b1);
      drain();

      // Stride overflow, then block_done colliding with a stride write
      blk_done(1'b0);
      set_base(32'h0000_3000);
      for (int s = 1; s <= 8; s++) wr_stride(SW'(s));
      wr_stride(16'h0100);
      step();
      chk("ovf_count_sat", {60'h0, cfg_loop_count}, 64'd8);
      send(it_all(16'd1), 1'b0, 32'h0000_3024, 1'b1);
      blk_done(1'b1);
      step();
      chk("clr_count", {60'h0, cfg_loop_count}, 64'd0);
      send(it_all(16'd1), 1'b0, 32'h0000_3000, 1'b1);
      wr_stride(16'd5);
      send(it_all(16'd1), 1'b1, 32'h0000_3005, 1'b1);
      drain();
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
